// File: rtl/pll_reset_sequencer.sv
// PLL reset supervisor: pulses the PLL reset, waits for a debounced lock,
// releases downstream channel resets one by one, and restarts on lock
// loss, lock timeout or software request. Keeps saturating diagnostics.
//
// state     | meaning
// PLL_RST   | pll_rst held high for PLL_RST_CYCLES, all channels in reset
// WAIT_LOCK | waiting for synchronised lock, bounded by LOCK_TIMEOUT
// DEBOUNCE  | lock must stay high for LOCK_STABLE consecutive cycles
// RELEASE   | one channel released every CH_DELAY cycles, bit 0 first
// RUN       | all channels released, ready high, lock monitored
module pll_reset_sequencer #(
   parameter int NUM_CH         = 2,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int LOCK_STABLE    = 1024,
   parameter int CH_DELAY       = 256,
   parameter int CNT_W          = 8
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              locked,
   input  logic              sw_reset,
   output logic              pll_rst,
   output logic [NUM_CH-1:0] rst_out,
   output logic              ready,
   output logic [CNT_W-1:0]  lol_count,
   output logic [CNT_W-1:0]  retry_count,
   output logic [2:0]        state_dbg
);

   localparam int MAX_A  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_B  = (LOCK_STABLE > CH_DELAY) ? LOCK_STABLE : CH_DELAY;
   localparam int MAX_T  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CTR_W  = $clog2(MAX_T);
   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [CTR_W-1:0] RST_TC    = CTR_W'(PLL_RST_CYCLES - 1);
   localparam logic [CTR_W-1:0] TO_TC     = CTR_W'(LOCK_TIMEOUT - 1);
   localparam logic [CTR_W-1:0] STABLE_TC = CTR_W'(LOCK_STABLE - 1);
   localparam logic [CTR_W-1:0] CH_TC     = CTR_W'(CH_DELAY - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CH - 1);

   localparam logic [2:0] S_PLL_RST   = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_DEBOUNCE  = 3'd2;
   localparam logic [2:0] S_RELEASE   = 3'd3;
   localparam logic [2:0] S_RUN       = 3'd4;

   logic [2:0]       state;
   logic [CTR_W-1:0] counter;
   logic [IDX_W-1:0] idx;
   logic             locked_m;
   logic             locked_s;
   logic             timeout;
   logic             lock_loss;
   logic             restart;

   assign state_dbg = state;

   // Restart conditions; sw_reset is ignored while the PLL is already held in reset.
   assign timeout   = (state == S_WAIT_LOCK) && !locked_s && (counter == TO_TC);
   assign lock_loss = ((state == S_RELEASE) || (state == S_RUN)) && !locked_s;
   assign restart   = (state != S_PLL_RST) && (sw_reset || timeout || lock_loss);

   // Lock synchroniser, sequencing FSM, channel release and diagnostic counters.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         locked_m    <= 1'b0;
         locked_s    <= 1'b0;
         state       <= S_PLL_RST;
         counter     <= '0;
         idx         <= '0;
         pll_rst     <= 1'b1;
         rst_out     <= '1;
         ready       <= 1'b0;
         lol_count   <= '0;
         retry_count <= '0;
      end else begin
         locked_m <= locked;
         locked_s <= locked_m;
         if (restart) begin
            state   <= S_PLL_RST;
            counter <= '0;
            pll_rst <= 1'b1;
            rst_out <= '1;
            ready   <= 1'b0;
            if (lock_loss && (lol_count != '1))
               lol_count <= lol_count + 1'b1;
            if (timeout && (retry_count != '1))
               retry_count <= retry_count + 1'b1;
         end else begin
            case (state)
               S_PLL_RST: begin
                  if (counter == RST_TC) begin
                     state   <= S_WAIT_LOCK;
                     pll_rst <= 1'b0;
                     counter <= '0;
                  end else begin
                     counter <= counter + 1'b1;
                  end
               end
               S_WAIT_LOCK: begin
                  if (locked_s) begin
                     state   <= S_DEBOUNCE;
                     counter <= '0;
                  end else begin
                     counter <= counter + 1'b1;
                  end
               end
               S_DEBOUNCE: begin
                  if (!locked_s) begin
                     state   <= S_WAIT_LOCK;
                     counter <= '0;
                  end else if (counter == STABLE_TC) begin
                     state   <= S_RELEASE;
                     counter <= '0;
                     idx     <= '0;
                  end else begin
                     counter <= counter + 1'b1;
                  end
               end
               S_RELEASE: begin
                  if (counter == CH_TC) begin
                     rst_out <= rst_out & ~(NUM_CH'(1) << idx);
                     idx     <= idx + 1'b1;
                     counter <= '0;
                     if (idx == LAST_IDX) begin
                        ready <= 1'b1;
                        state <= S_RUN;
                     end
                  end else begin
                     counter <= counter + 1'b1;
                  end
               end
               S_RUN: begin
                  rst_out <= '0;
                  ready   <= 1'b1;
               end
               default: begin
                  state   <= S_PLL_RST;
                  counter <= '0;
                  pll_rst <= 1'b1;
                  rst_out <= '1;
                  ready   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: hand-derived vector table, random
// stimulus against an elapsed-time reference model, timeout saturation
// and asynchronous reset checks.
module tb_pll_reset_sequencer;

   localparam int NUM_CH = 3;
   localparam int PRC    = 4;
   localparam int LTO    = 32;
   localparam int LST    = 8;
   localparam int CHD    = 5;
   localparam int CNT_W  = 8;

   logic              refclk = 1'b0;
   logic              rst;
   logic              locked;
   logic              sw_reset;
   logic              pll_rst;
   logic [NUM_CH-1:0] rst_out;
   logic              ready;
   logic [CNT_W-1:0]  lol_count;
   logic [CNT_W-1:0]  retry_count;
   logic [2:0]        state_dbg;

   int n_cmp = 0;
   int n_err = 0;

   pll_reset_sequencer #(
      .NUM_CH(NUM_CH), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO),
      .LOCK_STABLE(LST), .CH_DELAY(CHD), .CNT_W(CNT_W)
   ) dut (
      .refclk(refclk), .rst(rst), .locked(locked), .sw_reset(sw_reset),
      .pll_rst(pll_rst), .rst_out(rst_out), .ready(ready),
      .lol_count(lol_count), .retry_count(retry_count), .state_dbg(state_dbg)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      logic       lk;
      logic       sw;
      int         n;
      logic       e_pll;
      logic [2:0] e_rst;
      logic       e_rdy;
      logic [2:0] e_st;
      int         e_lol;
      int         e_retry;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic lk, logic sw, int n, logic p, logic [2:0] r,
                               logic rd, logic [2:0] st, int lol, int rt);
      vec_t v;
      v.lk = lk; v.sw = sw; v.n = n; v.e_pll = p; v.e_rst = r;
      v.e_rdy = rd; v.e_st = st; v.e_lol = lol; v.e_retry = rt;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all(input string nm, input logic p, input logic [2:0] r, input logic rd,
                            input logic [2:0] st, input int lol, input int rt);
      check({nm, ".pll_rst"}, 32'(pll_rst), 32'(p));
      check({nm, ".rst_out"}, 32'(rst_out), 32'(r));
      check({nm, ".ready"}, 32'(ready), 32'(rd));
      check({nm, ".state"}, 32'(state_dbg), 32'(st));
      check({nm, ".lol"}, 32'(lol_count), 32'(lol));
      check({nm, ".retry"}, 32'(retry_count), 32'(rt));
   endtask

   // Reference model: phase number plus cycles elapsed in that phase.
   int   m_ph, m_el, m_lol, m_retry;
   logic m_p0, m_p1;

   task automatic model_reset();
      m_ph = 0; m_el = 0; m_lol = 0; m_retry = 0; m_p0 = 1'b0; m_p1 = 1'b0;
   endtask

   task automatic model_step(input logic lk, input logic sw);
      logic ls;
      bit   to, loss;
      ls   = m_p1;
      m_p1 = m_p0;
      m_p0 = lk;
      to   = (m_ph == 1) && !ls && (m_el + 1 == LTO);
      loss = (m_ph >= 3) && !ls;
      if (m_ph != 0 && (sw || to || loss)) begin
         if (loss && m_lol < 255) m_lol++;
         if (to && m_retry < 255) m_retry++;
         m_ph = 0; m_el = 0;
      end else begin
         case (m_ph)
            0: begin m_el++; if (m_el == PRC) begin m_ph = 1; m_el = 0; end end
            1: begin if (ls) begin m_ph = 2; m_el = 0; end else m_el++; end
            2: begin
               if (!ls) begin m_ph = 1; m_el = 0; end
               else begin m_el++; if (m_el == LST) begin m_ph = 3; m_el = 0; end end
            end
            3: begin m_el++; if (m_el == NUM_CH * CHD) m_ph = 4; end
            default: ;
         endcase
      end
   endtask

   function automatic logic [31:0] model_vec();
      int released;
      logic [2:0] r;
      released = (m_ph == 4) ? NUM_CH : (m_ph == 3) ? (m_el / CHD) : 0;
      r = 3'(~((32'd1 << released) - 1));
      return {6'd0, (m_ph == 0), r, (m_ph == 4), 3'(m_ph), 8'(m_lol), 8'(m_retry)};
   endfunction

   task automatic do_reset();
      @(negedge refclk);
      rst = 1'b1; locked = 1'b0; sw_reset = 1'b0;
      model_reset();
      repeat (2) @(negedge refclk);
      rst = 1'b0;
   endtask

   initial begin
      bit found;
      rst = 1'b1; locked = 1'b0; sw_reset = 1'b0;
      repeat (3) @(negedge refclk);
      check_all("reset", 1'b1, 3'b111, 1'b0, 3'd0, 0, 0);
      rst = 1'b0;

      // startup
      tbl.push_back(mk(0,0,4,  0,3'b111,0,1,0,0));
      tbl.push_back(mk(0,0,10, 0,3'b111,0,1,0,0));
      tbl.push_back(mk(1,0,2,  0,3'b111,0,1,0,0));
      tbl.push_back(mk(1,0,1,  0,3'b111,0,2,0,0));
      tbl.push_back(mk(1,0,7,  0,3'b111,0,2,0,0));
      tbl.push_back(mk(1,0,1,  0,3'b111,0,3,0,0));
      tbl.push_back(mk(1,0,4,  0,3'b111,0,3,0,0));
      tbl.push_back(mk(1,0,1,  0,3'b110,0,3,0,0));
      tbl.push_back(mk(1,0,5,  0,3'b100,0,3,0,0));
      tbl.push_back(mk(1,0,4,  0,3'b100,0,3,0,0));
      tbl.push_back(mk(1,0,1,  0,3'b000,1,4,0,0));
      // lock loss in RUN
      tbl.push_back(mk(0,0,2,  0,3'b000,1,4,0,0));
      tbl.push_back(mk(0,0,1,  1,3'b111,0,0,1,0));
      tbl.push_back(mk(0,0,4,  0,3'b111,0,1,1,0));
      tbl.push_back(mk(1,0,3,  0,3'b111,0,2,1,0));
      tbl.push_back(mk(1,0,8,  0,3'b111,0,3,1,0));
      tbl.push_back(mk(1,0,5,  0,3'b110,0,3,1,0));
      // sw_reset mid-RELEASE
      tbl.push_back(mk(1,1,1,  1,3'b111,0,0,1,0));
      tbl.push_back(mk(1,0,4,  0,3'b111,0,1,1,0));
      tbl.push_back(mk(1,0,1,  0,3'b111,0,2,1,0));
      tbl.push_back(mk(1,0,8,  0,3'b111,0,3,1,0));
      tbl.push_back(mk(1,0,15, 0,3'b000,1,4,1,0));
      // sw_reset together with lock loss in RUN
      tbl.push_back(mk(0,0,2,  0,3'b000,1,4,1,0));
      tbl.push_back(mk(0,1,1,  1,3'b111,0,0,2,0));
      // timeouts
      tbl.push_back(mk(0,0,4,  0,3'b111,0,1,2,0));
      tbl.push_back(mk(0,0,32, 1,3'b111,0,0,2,1));
      tbl.push_back(mk(0,0,4,  0,3'b111,0,1,2,1));
      tbl.push_back(mk(0,0,31, 0,3'b111,0,1,2,1));
      tbl.push_back(mk(0,0,1,  1,3'b111,0,0,2,2));
      // sw_reset ignored in PLL_RST, then debounce glitch
      tbl.push_back(mk(1,1,1,  1,3'b111,0,0,2,2));
      tbl.push_back(mk(1,0,3,  0,3'b111,0,1,2,2));
      tbl.push_back(mk(1,0,1,  0,3'b111,0,2,2,2));
      tbl.push_back(mk(1,0,3,  0,3'b111,0,2,2,2));
      tbl.push_back(mk(0,0,3,  0,3'b111,0,1,2,2));
      tbl.push_back(mk(1,0,2,  0,3'b111,0,1,2,2));
      tbl.push_back(mk(1,0,1,  0,3'b111,0,2,2,2));
      tbl.push_back(mk(1,0,7,  0,3'b111,0,2,2,2));
      tbl.push_back(mk(1,0,1,  0,3'b111,0,3,2,2));
      tbl.push_back(mk(1,0,15, 0,3'b000,1,4,2,2));

      for (int i = 0; i < tbl.size(); i++) begin
         locked = tbl[i].lk;
         sw_reset = tbl[i].sw;
         repeat (tbl[i].n) @(posedge refclk);
         @(negedge refclk);
         check_all($sformatf("vec%0d", i), tbl[i].e_pll, tbl[i].e_rst, tbl[i].e_rdy,
                   tbl[i].e_st, tbl[i].e_lol, tbl[i].e_retry);
      end
      sw_reset = 1'b0;

      // random stimulus against the model
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if (locked) begin
            if ($urandom_range(0, 99) < 1) locked = 1'b0;
         end else begin
            if ($urandom_range(0, 99) < 4) locked = 1'b1;
         end
         sw_reset = ($urandom_range(0, 149) == 0);
         @(posedge refclk);
         model_step(locked, sw_reset);
         @(negedge refclk);
         check("rand", {6'd0, pll_rst, rst_out, ready, state_dbg, lol_count, retry_count},
               model_vec());
      end
      sw_reset = 1'b0;

      // retry_count saturation
      do_reset();
      repeat (300 * (PRC + LTO) + 10) @(posedge refclk);
      @(negedge refclk);
      check("sat.retry", 32'(retry_count), 32'd255);
      check("sat.rst_out", 32'(rst_out), 32'h7);
      check("sat.lol", 32'(lol_count), 32'd0);

      // async reset mid-RELEASE
      locked = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge refclk);
         if (rst_out == 3'b110) found = 1'b1;
      end
      check("arst.reach_release", 32'(found), 32'd1);
      check("arst.retry_before", 32'(retry_count), 32'd255);
      #1 rst = 1'b1;
      #1;
      check_all("arst", 1'b1, 3'b111, 1'b0, 3'd0, 0, 0);
      @(negedge refclk);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
